// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   IO-write bus between the CPU's IO decode and the seven-segment display.
//   The CPU side drives every signal. The display only samples them.
//
//   segwrite : write strobe from IO decode, active high
//   segcs    : chip select; the display is the selected output device
//   segaddr  : register select (00 value low, 10 value high, 01 control, 11 none)
//   segwdata : 16-bit write data
interface seg7_scan_display_if;
  logic        segwrite;
  logic        segcs;
  logic [1:0]  segaddr;
  logic [15:0] segwdata;

  modport master (
    output segwrite,
    output segcs,
    output segaddr,
    output segwdata
  );

  modport slave (
    input  segwrite,
    input  segcs,
    input  segaddr,
    input  segwdata
  );
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Memory-mapped driver for an 8-digit, common-anode seven-segment display.
//   The CPU loads a 32-bit value, a per-digit blank mask and a per-digit
//   decimal-point mask. The block lights one digit at a time. Each digit stays
//   lit for SCAN_DIV clock cycles, so a full frame is 8*SCAN_DIV cycles.
//
//   Parameters
//     SCAN_DIV : clock cycles per digit slot (1..65535)
//
//   Ports
//     clock    : system clock
//     reset    : synchronous, active-high reset
//     bus      : IO-write bus (slave side): segwrite, segcs, segaddr, segwdata
//     seg_en   : digit enables, active low; bit i = digit i (digit 0 rightmost)
//     seg_out  : segments, active low, {dp,g,f,e,d,c,b,a}
module seg7_scan_display #(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic                      clock,
  input  logic                      reset,
  seg7_scan_display_if.slave        bus,
  output logic [7:0]                seg_en,
  output logic [7:0]                seg_out
);

  // Terminal count of the slot divider. With SCAN_DIV = 1 this is 0, so
  // every cycle is a terminal cycle and the digit index advances each clock.
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  localparam logic [1:0] ADDR_VAL_LO = 2'b00;
  localparam logic [1:0] ADDR_CTRL   = 2'b01;
  localparam logic [1:0] ADDR_VAL_HI = 2'b10;

  // Register file
  logic [31:0] value_r;
  logic [7:0]  blank_r;
  logic [7:0]  dpmask_r;

  // Scan timing
  logic [15:0] div_cnt;
  logic [2:0]  idx;
  logic        div_last;

  // Output stage
  logic        wr_en;
  logic [3:0]  nib_p0;
  logic [7:0]  seg_en_p0;
  logic [7:0]  seg_out_p0;
  logic [7:0]  seg_en_p1;
  logic [7:0]  seg_out_p1;

  // Active-low hex font for segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Active-low one-hot digit enable. A blanked digit turns every anode off.
  function automatic logic [7:0] digit_enable(input logic [2:0] sel,
                                              input logic [7:0] blank_mask);
    logic [7:0] en;
    if (blank_mask[sel]) en = 8'hFF;
    else                 en = ~(8'h01 << sel);
    return en;
  endfunction

  assign wr_en    = bus.segcs && bus.segwrite;
  assign div_last = (div_cnt == DIV_LAST);

  // Register writes. A write never touches the scan counters, so the CPU can
  // update the display at any time without shifting the slot timing.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r  <= 32'h0;
      blank_r  <= 8'h0;
      dpmask_r <= 8'h0;
    end else if (wr_en) begin
      case (bus.segaddr)
        ADDR_VAL_LO: value_r[15:0]       <= bus.segwdata;
        ADDR_VAL_HI: value_r[31:16]      <= bus.segwdata;
        ADDR_CTRL:   {dpmask_r, blank_r} <= bus.segwdata;
        default:     ;
      endcase
    end
  end

  // Slot divider and digit index. idx wraps 7 -> 0 by natural 3-bit overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= 16'h0;
      idx     <= 3'd0;
    end else if (div_last) begin
      div_cnt <= 16'h0;
      idx     <= idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 16'h1;
    end
  end

  // ---- p0: combinational digit decode from the current idx and registers ----
  // The segment pattern is decoded even when the digit is blanked. The anodes
  // are off then, so the pattern never shows.
  always_comb begin
    nib_p0     = value_r[{idx, 2'b00} +: 4];
    seg_en_p0  = digit_enable(idx, blank_r);
    seg_out_p0 = {~dpmask_r[idx], hex_to_seg(nib_p0)};
  end

  // ---- p1: registered pin drivers, reloaded every cycle ----
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_en_p1  <= 8'hFF;
      seg_out_p1 <= 8'hFF;
    end else begin
      seg_en_p1  <= seg_en_p0;
      seg_out_p1 <= seg_out_p0;
    end
  end

  assign seg_en  = seg_en_p1;
  assign seg_out = seg_out_p1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display
//   Scoreboard bench for seg7_scan_display. The main instance runs with
//   SCAN_DIV = 4. A second instance with SCAN_DIV = 1 shares the same bus and
//   covers the every-cycle advance case. A cycle model counts clocks since
//   reset. It pushes one expected output per rising edge. Each test task pops
//   these entries at the falling edge and compares them. The tasks also check
//   fixed values taken from the display font.
module tb_seg7_scan_display;

  localparam int SCAN  = 4;
  localparam int FRAME = 8 * SCAN;

  logic       clock;
  logic       reset;
  logic [7:0] seg_en, seg_out;
  logic [7:0] seg_en1, seg_out1;

  seg7_scan_display_if bus ();

  seg7_scan_display #(.SCAN_DIV(SCAN)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .seg_en  (seg_en),
    .seg_out (seg_out)
  );

  seg7_scan_display #(.SCAN_DIV(1)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .seg_en  (seg_en1),
    .seg_out (seg_out1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic [2:0] idx;
    logic [7:0] en;
    logic [7:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model. It tracks the cycle position within a frame
  // (0..FRAME-1). It does not keep a separate divider and index.
  logic [31:0] m_value;
  logic [7:0]  m_blank, m_dp;
  int          m_cnt;
  int          m_d;
  logic [3:0]  m_nib;
  exp_t        m_e;

  always @(posedge clock) begin
    if (reset) begin
      m_e = '{rst: 1'b1, idx: 3'd0, en: 8'hFF, out: 8'hFF};
      exp_q.push_back(m_e);
      m_value <= 32'h0;
      m_blank <= 8'h0;
      m_dp    <= 8'h0;
      m_cnt   <= 0;
    end else begin
      m_d       = m_cnt / SCAN;
      m_nib     = 4'(m_value >> (4 * m_d));
      m_e.rst   = 1'b0;
      m_e.idx   = 3'(m_d);
      m_e.en    = m_blank[m_d] ? 8'hFF : ~(8'h01 << m_d);
      m_e.out   = hex_tab[m_nib] & {~m_dp[m_d], 7'h7F};
      exp_q.push_back(m_e);
      if (bus.segcs && bus.segwrite) begin
        if (bus.segaddr == 2'b00) m_value[15:0]  <= bus.segwdata;
        if (bus.segaddr == 2'b10) m_value[31:16] <= bus.segwdata;
        if (bus.segaddr == 2'b01) begin
          m_blank <= bus.segwdata[7:0];
          m_dp    <= bus.segwdata[15:8];
        end
      end
      m_cnt <= (m_cnt + 1) % FRAME;
    end
  end

  task automatic drive(input logic w, input logic cs, input logic [1:0] a,
                       input logic [15:0] d);
    bus.segwrite = w;
    bus.segcs    = cs;
    bus.segaddr  = a;
    bus.segwdata = d;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [7:0] want_en;
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 16'h0);
    @(negedge clock);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL reset_model: no expected entry");
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({seg_en, seg_out} !== {e.en, e.out}) begin
          n_fail++; $display("FAIL reset_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
        end
      end
      n_checks++;
      if ({seg_en, seg_out} !== 16'hFFFF) begin
        n_fail++; $display("FAIL reset_hold: got %h/%h expected ff/ff", seg_en, seg_out);
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL idle_model: no expected entry");
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({seg_en, seg_out} !== {e.en, e.out}) begin
          n_fail++; $display("FAIL idle_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
        end
      end
      want_en = ~(8'h01 << ((k / SCAN) % 8));
      n_checks++;
      if (seg_en !== want_en || seg_out !== 8'hC0) begin
        n_fail++; $display("FAIL idle_scan k=%0d: got %h/%h expected %h/c0", k, seg_en, seg_out, want_en);
      end
    end
  endtask

  task automatic test_scan_div1();
    exp_t e;
    logic [7:0] want_en;
    @(negedge clock);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clock);
    e = exp_q.pop_front();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL div1_model: no expected entry");
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({seg_en, seg_out} !== {e.en, e.out}) begin
          n_fail++; $display("FAIL div1_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
        end
      end
      want_en = ~(8'h01 << (k % 8));
      n_checks++;
      if (seg_en1 !== want_en || seg_out1 !== 8'hC0) begin
        n_fail++; $display("FAIL div1_scan k=%0d: got %h/%h expected %h/c0", k, seg_en1, seg_out1, want_en);
      end
    end
  endtask

  task automatic test_halfword();
    exp_t e;
    logic [7:0] want [8] = '{8'h83, 8'h88, 8'h90, 8'h80, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    @(negedge clock);
    exp_q.delete();
    drive(1'b1, 1'b1, 2'b00, 16'h89AB);
    @(negedge clock);
    e = exp_q.pop_front();
    drive(1'b1, 1'b1, 2'b10, 16'h0123);
    @(negedge clock);
    e = exp_q.pop_front();
    drive(1'b0, 1'b0, 2'b00, 16'h0);
    for (int k = 0; k < FRAME + 2; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL halfword_model: no expected entry");
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({seg_en, seg_out} !== {e.en, e.out}) begin
          n_fail++; $display("FAIL halfword_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
        end
        n_checks++;
        if (seg_out !== want[e.idx]) begin
          n_fail++; $display("FAIL halfword_digit%0d: got %h expected %h", e.idx, seg_out, want[e.idx]);
        end
      end
    end
  endtask

  task automatic test_control();
    exp_t e;
    logic [7:0] want_en;
    @(negedge clock);
    exp_q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      // Pass 0 loads the control word. Pass 1 writes to the unused address.
      if (pass == 0) drive(1'b1, 1'b1, 2'b01, 16'h0381);
      else           drive(1'b1, 1'b1, 2'b11, 16'hFFFF);
      @(negedge clock);
      e = exp_q.pop_front();
      drive(1'b0, 1'b0, 2'b00, 16'h0);
      for (int k = 0; k < FRAME + 2; k++) begin
        @(negedge clock);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL control_model: no expected entry");
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if ({seg_en, seg_out} !== {e.en, e.out}) begin
            n_fail++; $display("FAIL control_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
          end
          if (k > 0) begin
            want_en = (e.idx == 3'd0 || e.idx == 3'd7) ? 8'hFF : ~(8'h01 << e.idx);
            n_checks++;
            if (seg_en !== want_en) begin
              n_fail++; $display("FAIL control_blank%0d: got %h expected %h", e.idx, seg_en, want_en);
            end
            n_checks++;
            if (seg_out[7] !== (e.idx > 3'd1)) begin
              n_fail++; $display("FAIL control_dp%0d: got %b expected %b", e.idx, seg_out[7], (e.idx > 3'd1));
            end
            if (e.idx == 3'd1) begin
              n_checks++;
              if (seg_out !== 8'h08) begin
                n_fail++; $display("FAIL control_digit1: got %h expected 08", seg_out);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic test_gating();
    exp_t e;
    @(negedge clock);
    exp_q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) drive(1'b1, 1'b0, 2'b00, 16'hFFFF);
      else           drive(1'b0, 1'b1, 2'b00, 16'hFFFF);
      @(negedge clock);
      e = exp_q.pop_front();
      drive(1'b0, 1'b0, 2'b00, 16'h0);
      for (int k = 0; k < FRAME + 2; k++) begin
        @(negedge clock);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL gating_model: no expected entry");
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if ({seg_en, seg_out} !== {e.en, e.out}) begin
            n_fail++; $display("FAIL gating_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
          end
          if (e.idx == 3'd2 || e.idx == 3'd3) begin
            n_checks++;
            if (seg_out !== ((e.idx == 3'd2) ? 8'h90 : 8'h80)) begin
              n_fail++; $display("FAIL gating_digit%0d: got %h expected %h", e.idx, seg_out,
                                 (e.idx == 3'd2) ? 8'h90 : 8'h80);
            end
          end
        end
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    bit   found = 1'b0;
    @(negedge clock);
    exp_q.delete();
    drive(1'b1, 1'b1, 2'b01, 16'h0000);
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({seg_en, seg_out} !== {e.en, e.out}) begin
          n_fail++; $display("FAIL collision_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
        end
      end
      drive(1'b0, 1'b0, 2'b00, 16'h0);
      // The next rising edge is the one where digit 7 wraps to digit 0.
      if (m_cnt == FRAME - 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL collision_wait: got timeout expected wrap edge");
    end else begin
      drive(1'b1, 1'b1, 2'b00, 16'h000F);
      @(negedge clock);
      e = exp_q.pop_front();
      drive(1'b0, 1'b0, 2'b00, 16'h0);
      @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if ({seg_en, seg_out} !== {e.en, e.out}) begin
        n_fail++; $display("FAIL collision_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
      end
      n_checks++;
      if ({seg_en, seg_out} !== 16'hFE8E) begin
        n_fail++; $display("FAIL collision_out: got %h/%h expected fe/8e", seg_en, seg_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   found = 1'b0;
    @(negedge clock);
    exp_q.delete();
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({seg_en, seg_out} !== {e.en, e.out}) begin
          n_fail++; $display("FAIL midreset_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
        end
      end
      if (m_cnt / SCAN == 5) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL midreset_wait: got timeout expected digit 5");
    end else begin
      reset = 1'b1;
      drive(1'b1, 1'b1, 2'b00, 16'h5555);
      for (int k = 0; k < 2; k++) begin
        @(negedge clock);
        e = exp_q.pop_front();
        drive(1'b0, 1'b0, 2'b00, 16'h0);
        n_checks++;
        if ({seg_en, seg_out} !== 16'hFFFF) begin
          n_fail++; $display("FAIL midreset_hold: got %h/%h expected ff/ff", seg_en, seg_out);
        end
      end
      reset = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        @(negedge clock);
        e = exp_q.pop_front();
        n_checks++;
        if ({seg_en, seg_out} !== {e.en, e.out}) begin
          n_fail++; $display("FAIL midreset_model: got %h/%h expected %h/%h", seg_en, seg_out, e.en, e.out);
        end
        n_checks++;
        if (seg_out !== 8'hC0 || (k == 0 && seg_en !== 8'hFE)) begin
          n_fail++; $display("FAIL midreset_release k=%0d: got %h/%h expected fe/c0 then */c0", k, seg_en, seg_out);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 16'h0);
    test_reset();
    test_scan_div1();
    test_halfword();
    test_control();
    test_gating();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
